// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate checker placed after the Viterbi decoder: a reference-bit FIFO
// absorbs the decoder latency, decoded bits are compared and counted over WINDOW.
module viterbi_ber_checker #(
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             ref_valid_i,
    input  logic             ref_bit_i,
    input  logic             dec_valid_i,
    input  logic             dec_bit_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             mismatch_o,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             ovf_o,
    output logic             udf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;

    logic running;
    logic pop_ok;
    logic push_ok;
    logic head_bit;
    logic window_end;

    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    always_comb begin
        running    = (state == RUN) && !start_i;
        pop_ok     = running && dec_valid_i && (level != '0);
        push_ok    = running && ref_valid_i && ((level != FULL) || pop_ok);
        window_end = pop_ok && (bit_cnt_o == LAST);
        head_bit   = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start_i) begin
            state_next = RUN;
        end else if ((state == RUN) && window_end) begin
            state_next = DONE;
        end
    end

    assign busy_o = (state == RUN);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= ref_bit_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            bit_cnt_o  <= '0;
            err_cnt_o  <= '0;
            ovf_o      <= 1'b0;
            udf_o      <= 1'b0;
            mismatch_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            mismatch_o <= 1'b0;
            done_o     <= 1'b0;
            if (start_i) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                bit_cnt_o <= '0;
                err_cnt_o <= '0;
                ovf_o     <= 1'b0;
                udf_o     <= 1'b0;
            end else if (state == RUN) begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop_ok) begin
                    rd_ptr    <= rd_ptr + AW'(1);
                    bit_cnt_o <= bit_cnt_o + CNT_W'(1);
                    if (dec_bit_i != head_bit) begin
                        mismatch_o <= 1'b1;
                        if (err_cnt_o != '1) begin
                            err_cnt_o <= err_cnt_o + CNT_W'(1);
                        end
                    end
                end
                if (window_end) begin
                    done_o <= 1'b1;
                end
                // Underflow looks only at the registered level, never at a same-cycle push.
                if (ref_valid_i && (level == FULL) && !pop_ok) begin
                    ovf_o <= 1'b1;
                end
                if (dec_valid_i && (level == '0)) begin
                    udf_o <= 1'b1;
                end
                if (push_ok && !pop_ok) begin
                    level <= level + (AW+1)'(1);
                end else if (pop_ok && !push_ok) begin
                    level <= level - (AW+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Randomized directed bench for viterbi_ber_checker against a queue-based reference model.
module tb_viterbi_ber_checker;

    localparam int DEPTH   = 64;
    localparam int CNT_W   = 16;
    localparam int WINDOW  = 256;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, start, ref_v, ref_b, dec_v, dec_b;
    logic busy, done, mism, ovf, udf;
    logic [CNT_W-1:0] bit_cnt, err_cnt;

    logic b_start, b_ref_v, b_ref_b, b_dec_v, b_dec_b;
    logic b_busy, b_done, b_mism, b_ovf, b_udf;
    logic [3:0] b_bit_cnt, b_err_cnt;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int mis_seen = 0;
    string phase = "reset";

    bit ref_q[$];
    int m_cnt, m_err;
    bit m_ovf, m_udf, m_mis, m_done, m_run;

    viterbi_ber_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .start_i(start),
        .ref_valid_i(ref_v), .ref_bit_i(ref_b),
        .dec_valid_i(dec_v), .dec_bit_i(dec_b),
        .busy_o(busy), .done_o(done), .mismatch_o(mism),
        .bit_cnt_o(bit_cnt), .err_cnt_o(err_cnt),
        .ovf_o(ovf), .udf_o(udf)
    );

    viterbi_ber_checker #(.DEPTH(DEPTH), .CNT_W(4), .WINDOW(15)) dut_small (
        .clk(clk), .rst(rst), .start_i(b_start),
        .ref_valid_i(b_ref_v), .ref_bit_i(b_ref_b),
        .dec_valid_i(b_dec_v), .dec_bit_i(b_dec_b),
        .busy_o(b_busy), .done_o(b_done), .mismatch_o(b_mism),
        .bit_cnt_o(b_bit_cnt), .err_cnt_o(b_err_cnt),
        .ovf_o(b_ovf), .udf_o(b_udf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput({phase, ".busy"},    32'(busy),    32'(m_run));
        checkOutput({phase, ".done"},    32'(done),    32'(m_done));
        checkOutput({phase, ".mismatch"},32'(mism),    32'(m_mis));
        checkOutput({phase, ".bit_cnt"}, 32'(bit_cnt), m_cnt);
        checkOutput({phase, ".err_cnt"}, 32'(err_cnt), m_err);
        checkOutput({phase, ".ovf"},     32'(ovf),     32'(m_ovf));
        checkOutput({phase, ".udf"},     32'(udf),     32'(m_udf));
    endtask

    // Reference model: the FIFO is a plain queue; level is its size before this cycle.
    task automatic modelStep(input bit s, input bit rv, input bit rb, input bit dv, input bit db);
        int had;
        bit popped;
        bit head;
        m_mis  = 0;
        m_done = 0;
        if (s) begin
            ref_q.delete();
            m_cnt = 0; m_err = 0; m_ovf = 0; m_udf = 0; m_run = 1;
        end else if (m_run) begin
            had    = ref_q.size();
            popped = 0;
            if (dv) begin
                if (had > 0) begin
                    head = ref_q.pop_front();
                    popped = 1;
                    m_cnt++;
                    if (head != db) begin
                        m_mis = 1;
                        if (m_err < CNT_MAX) m_err++;
                    end
                end else begin
                    m_udf = 1;
                end
            end
            if (rv) begin
                if (had < DEPTH || popped) ref_q.push_back(rb);
                else m_ovf = 1;
            end
            if (m_cnt == WINDOW) begin
                m_run  = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic applyStimulus(input bit s, input bit rv, input bit rb, input bit dv, input bit db);
        start = s; ref_v = rv; ref_b = rb; dec_v = dv; dec_b = db;
        modelStep(s, rv, rb, dv, db);
        @(posedge clk);
        #1;
        checkAll();
        if (done) done_seen++;
        if (mism) mis_seen++;
    endtask

    task automatic applyReset();
        rst = 1; start = 0; ref_v = 0; ref_b = 0; dec_v = 0; dec_b = 0;
        ref_q.delete();
        m_cnt = 0; m_err = 0; m_ovf = 0; m_udf = 0; m_mis = 0; m_done = 0; m_run = 0;
        @(posedge clk);
        #1;
        rst = 0;
        checkAll();
    endtask

    // Reference stream of n bits; the decoded copy trails by delay cycles.
    task automatic runDelayed(input int n, input int delay, input int f0, input int f1,
                              input int f2, input int max_cycles);
        bit bits[$];
        bit rv, rb, dv, db;
        int k;
        for (int i = 0; i < n; i++) bits.push_back(1'($urandom_range(0, 1)));
        for (int t = 0; t < n + delay && t < max_cycles; t++) begin
            k  = t - delay;
            rv = (t < n);
            rb = rv ? bits[t] : 1'b0;
            dv = (k >= 0) && (k < n);
            db = dv ? (bits[k] ^ ((k == f0) || (k == f1) || (k == f2))) : 1'b0;
            applyStimulus(0, rv, rb, dv, db);
        end
    endtask

    task automatic applySmall(input bit s, input bit rv, input bit rb, input bit dv, input bit db);
        b_start = s; b_ref_v = rv; b_ref_b = rb; b_dec_v = dv; b_dec_b = db;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit sb[$];
        b_start = 0; b_ref_v = 0; b_ref_b = 0; b_dec_v = 0; b_dec_b = 0;
        applyReset();
        applyReset();
        checkOutput("reset.busy_const", 32'(busy), 0);

        phase = "t1_clean";
        done_seen = 0;
        applyStimulus(1, 0, 0, 0, 0);
        runDelayed(256, 20, -1, -1, -1, 1000);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1.done_count", done_seen, 1);
        checkOutput("t1.bit_cnt", 32'(bit_cnt), 256);
        checkOutput("t1.err_cnt", 32'(err_cnt), 0);
        checkOutput("t1.ovf_udf", 32'({ovf, udf}), 0);

        phase = "t2_errors";
        done_seen = 0;
        mis_seen = 0;
        applyStimulus(1, 0, 0, 0, 0);
        runDelayed(256, 20, 7, 15, 16, 1000);
        checkOutput("t2.err_cnt", 32'(err_cnt), 3);
        checkOutput("t2.mismatch_pulses", mis_seen, 3);
        checkOutput("t2.done_count", done_seen, 1);

        phase = "t3_overflow";
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 65; i++) applyStimulus(0, 1, 1'($urandom_range(0, 1)), 0, 0);
        checkOutput("t3.ovf_after_65", 32'(ovf), 1);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)));
        checkOutput("t3.ovf_held", 32'(ovf), 1);
        checkOutput("t3.bit_cnt_full_pp", 32'(bit_cnt), 5);
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) applyStimulus(0, 1, 1'($urandom_range(0, 1)), 0, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)));
        checkOutput("t3.no_ovf_full_pp", 32'(ovf), 0);
        for (int i = 0; i < 64; i++) applyStimulus(0, 0, 0, 1, 1'($urandom_range(0, 1)));
        checkOutput("t3.level64_drained", 32'(bit_cnt), 69);
        checkOutput("t3.no_udf_drain", 32'(udf), 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t3.udf_past_empty", 32'(udf), 1);
        checkOutput("t3.bit_cnt_hold", 32'(bit_cnt), 69);

        phase = "t4_underflow";
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("t4.udf", 32'(udf), 1);
        checkOutput("t4.bit_cnt", 32'(bit_cnt), 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 1);
        checkOutput("t4.udf_pp", 32'(udf), 1);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("t4.level_one", 32'(bit_cnt), 1);
        checkOutput("t4.err_zero", 32'(err_cnt), 0);

        phase = "t5_abort";
        done_seen = 0;
        applyStimulus(1, 0, 0, 0, 0);
        runDelayed(256, 20, -1, -1, -1, 120);
        checkOutput("t5.bit_cnt_100", 32'(bit_cnt), 100);
        applyReset();
        checkOutput("t5.reset_outputs", 32'({busy, done, mism, ovf, udf, bit_cnt, err_cnt}), 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 1, 0);
        checkOutput("t5.no_done", done_seen, 0);

        phase = "t5_restart";
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        runDelayed(256, 20, 3, -1, -1, 1000);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 1, 1);
        checkOutput("t5.done_hold_cnt", 32'(bit_cnt), 256);
        checkOutput("t5.done_hold_udf", 32'(udf), 1);
        applyStimulus(1, 1, 1, 1, 1);
        checkOutput("t5.restart_busy", 32'(busy), 1);
        checkOutput("t5.restart_clear", 32'({ovf, udf, bit_cnt, err_cnt}), 0);

        phase = "random";
        done_seen = 0;
        for (int t = 0; t < 4000 && m_run; t++) begin
            applyStimulus(t == 100, $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 99) < 50, 1'($urandom_range(0, 1)));
        end
        checkOutput("random.window_end", 32'(busy), 0);
        checkOutput("random.done_count", done_seen, 1);

        phase = "t6_saturate";
        applySmall(1, 0, 0, 0, 0);
        checkOutput("t6.busy", 32'(b_busy), 1);
        for (int i = 0; i < 15; i++) begin
            sb.push_back(1'($urandom_range(0, 1)));
            applySmall(0, 1, sb[i], 0, 0);
        end
        for (int i = 0; i < 15; i++) begin
            applySmall(0, 0, 0, 1, ~sb[i]);
            checkOutput($sformatf("t6.mismatch%0d", i), 32'(b_mism), 1);
        end
        checkOutput("t6.done", 32'(b_done), 1);
        checkOutput("t6.busy_drop", 32'(b_busy), 0);
        checkOutput("t6.err_cnt", 32'(b_err_cnt), 15);
        checkOutput("t6.bit_cnt", 32'(b_bit_cnt), 15);
        for (int i = 0; i < 5; i++) applySmall(0, 1, 0, 1, 1);
        checkOutput("t6.err_held", 32'(b_err_cnt), 15);
        checkOutput("t6.done_once", 32'(b_done), 0);
        checkOutput("t6.flags", 32'({b_ovf, b_udf}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
